// File: rtl/factor_entry_ctrl_pkg.sv
// Shared definitions for the factor entry controller: state encoding,
// button bit positions, default sizes and BCD digit step helpers.
package factor_entry_ctrl_pkg;

    localparam int NDIG_DEF = 4;
    localparam int BW_DEF   = 14;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDIT   = 3'd1,
        S_CONV   = 3'd2,
        S_SUBMIT = 3'd3,
        S_WAIT   = 3'd4,
        S_SHOW   = 3'd5
    } state_t;

    localparam int B_INC   = 0;
    localparam int B_DEC   = 1;
    localparam int B_SEL   = 2;
    localparam int B_CLR   = 3;
    localparam int B_QUE   = 4;
    localparam int B_READY = 5;

    // Non-decimal codes snap back into range so a corrupted digit self-heals.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/factor_entry_ctrl_bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first.
// done_o/result_o are valid in the cycle the last digit is folded in.
module bcd_to_bin_seq
    import factor_entry_ctrl_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int BW   = BW_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_i,
    input  logic [NDIG-1:0][3:0] digits_i,
    output logic                 done_o,
    output logic [BW-1:0]        result_o
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [BW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] acc_x10_s;
    logic [BW-1:0] mac_s;

    // acc*10 as two shifts; truncation to BW is intentional
    assign acc_x10_s = (acc_q << 3'd3) + (acc_q << 3'd1);
    assign mac_s     = acc_x10_s + {{(BW-4){1'b0}}, digits_i[idx_q]};
    assign done_o    = busy_q && (idx_q == '0);
    assign result_o  = mac_s;

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        if (start_i) begin
            acc_d  = '0;
            idx_d  = IW'(NDIG - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = mac_s;
            if (idx_q == '0) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/factor_entry_ctrl.sv
// Button-driven BCD entry, conversion and operand handoff to the factorizer.
// Optional build macro TIMEOUT_EN adds an idle timeout in EDIT/SHOW.
module factor_entry_ctrl
    import factor_entry_ctrl_pkg::*;
#(
    parameter int NDIG        = NDIG_DEF,
    parameter int BW          = BW_DEF,
    parameter int TIMEOUT_CYC = 500000000,
    localparam int CW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [6:0]        BTN,
    output logic [4*NDIG-1:0] DIGITS,
    output logic [CW-1:0]     CUR,
    output logic              OP_VALID,
    input  logic              OP_READY,
    output logic [BW-1:0]     OP_DATA,
    input  logic              DONE,
    output logic              ERR,
    output logic [2:0]        STATE
);

    state_t               state_q, state_d;
    logic [NDIG-1:0][3:0] digits_q, digits_d;
    logic [CW-1:0]        cur_q, cur_d;
    logic                 err_q, err_d;
    logic                 op_valid_q, op_valid_d;
    logic [BW-1:0]        op_data_q, op_data_d;

    logic          btn_inc_s, btn_dec_s, btn_sel_s, btn_clr_s, btn_que_s, btn_ready_s;
    logic          btn_any_s;
    logic          unused_btn_s;
    logic          xfer_s;
    logic          conv_start_s;
    logic          conv_done_s;
    logic [BW-1:0] conv_result_s;
    logic          conv_low_s;
    logic          tmo_hit_s;

    assign btn_inc_s    = BTN[B_INC];
    assign btn_dec_s    = BTN[B_DEC];
    assign btn_sel_s    = BTN[B_SEL];
    assign btn_clr_s    = BTN[B_CLR];
    assign btn_que_s    = BTN[B_QUE];
    assign btn_ready_s  = BTN[B_READY];
    assign btn_any_s    = |BTN[5:0];
    assign unused_btn_s = BTN[6];
    assign xfer_s       = op_valid_q && OP_READY;
    assign conv_low_s   = conv_result_s < BW'(2);
    assign conv_start_s = (state_d == S_CONV) && (state_q != S_CONV);

    bcd_to_bin_seq #(.NDIG(NDIG), .BW(BW)) u_conv (
        .CLK      (CLK),
        .RST      (RST),
        .start_i  (conv_start_s),
        .digits_i (digits_q),
        .done_o   (conv_done_s),
        .result_o (conv_result_s)
    );

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_run_s;

    // A same-cycle button always beats the timeout.
    assign tmo_run_s = (state_q == S_EDIT) || (state_q == S_SHOW);
    assign tmo_hit_s = tmo_run_s && !btn_any_s && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        if (!tmo_run_s || btn_any_s || (state_d != state_q)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign tmo_hit_s = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = btn_ready_s ? S_EDIT : S_IDLE;
                S_EDIT: begin
                    if (btn_clr_s) begin
                        state_d = S_EDIT;
                    end else if (btn_que_s) begin
                        state_d = S_CONV;
                    end else begin
                        state_d = S_EDIT;
                    end
                end
                S_CONV: begin
                    if (conv_done_s) begin
                        state_d = conv_low_s ? S_EDIT : S_SUBMIT;
                    end else begin
                        state_d = S_CONV;
                    end
                end
                // CLR outranks a same-cycle transfer
                S_SUBMIT: begin
                    if (btn_clr_s) begin
                        state_d = S_EDIT;
                    end else if (xfer_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_SUBMIT;
                    end
                end
                S_WAIT:   state_d = DONE ? S_SHOW : S_WAIT;
                S_SHOW: begin
                    if (btn_ready_s || btn_clr_s) begin
                        state_d = S_EDIT;
                    end else if (btn_que_s) begin
                        state_d = S_CONV;
                    end else begin
                        state_d = S_SHOW;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        digits_d   = digits_q;
        cur_d      = cur_q;
        err_d      = err_q;
        op_valid_d = op_valid_q;
        op_data_d  = op_data_q;
        if (tmo_hit_s) begin
            digits_d = '0;
            cur_d    = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_SHOW: begin
                    if (btn_ready_s || ((state_q == S_SHOW) && btn_clr_s)) begin
                        digits_d = '0;
                        cur_d    = '0;
                        err_d    = 1'b0;
                    end else begin
                        err_d = err_q;
                    end
                end
                // single highest-priority button acts: CLR > QUE > SEL > INC > DEC
                S_EDIT: begin
                    if (btn_clr_s) begin
                        digits_d = '0;
                        cur_d    = '0;
                        err_d    = 1'b0;
                    end else if (btn_que_s) begin
                        err_d = err_q;
                    end else if (btn_sel_s) begin
                        cur_d = (cur_q == CW'(NDIG - 1)) ? '0 : cur_q + 1'b1;
                    end else if (btn_inc_s) begin
                        digits_d[cur_q] = bcd_inc(digits_q[cur_q]);
                        err_d           = 1'b0;
                    end else if (btn_dec_s) begin
                        digits_d[cur_q] = bcd_dec(digits_q[cur_q]);
                        err_d           = 1'b0;
                    end else begin
                        err_d = err_q;
                    end
                end
                S_CONV: begin
                    if (conv_done_s && conv_low_s) begin
                        err_d = 1'b1;
                    end else if (conv_done_s) begin
                        op_valid_d = 1'b1;
                        op_data_d  = conv_result_s;
                    end else begin
                        op_valid_d = 1'b0;
                    end
                end
                S_SUBMIT: begin
                    if (btn_clr_s || xfer_s) begin
                        op_valid_d = 1'b0;
                    end else begin
                        op_valid_d = op_valid_q;
                    end
                end
                S_WAIT:  op_valid_d = 1'b0;
                default: op_valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            digits_q   <= '0;
            cur_q      <= '0;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_data_q  <= '0;
        end else begin
            digits_q   <= digits_d;
            cur_q      <= cur_d;
            err_q      <= err_d;
            op_valid_q <= op_valid_d;
            op_data_q  <= op_data_d;
        end
    end

    assign DIGITS   = digits_q;
    assign CUR      = cur_q;
    assign ERR      = err_q;
    assign OP_VALID = op_valid_q;
    assign OP_DATA  = op_data_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_factor_entry_ctrl.sv
// Directed bench for factor_entry_ctrl; operand transfers are checked
// against a queue of expected values pushed when each submit is requested.
module tb_factor_entry_ctrl;

    localparam logic [6:0] P_INC = 7'h01;
    localparam logic [6:0] P_DEC = 7'h02;
    localparam logic [6:0] P_SEL = 7'h04;
    localparam logic [6:0] P_CLR = 7'h08;
    localparam logic [6:0] P_QUE = 7'h10;
    localparam logic [6:0] P_RDY = 7'h20;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  BTN = 7'h00;
    logic        OP_READY = 1'b0;
    logic        DONE = 1'b0;
    logic [15:0] DIGITS;
    logic [1:0]  CUR;
    logic        OP_VALID;
    logic [13:0] OP_DATA;
    logic        ERR;
    logic [2:0]  STATE;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int obs_q[$];

    always #5 CLK = ~CLK;

    factor_entry_ctrl #(.NDIG(4), .BW(14), .TIMEOUT_CYC(100)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN      (BTN),
        .DIGITS   (DIGITS),
        .CUR      (CUR),
        .OP_VALID (OP_VALID),
        .OP_READY (OP_READY),
        .OP_DATA  (OP_DATA),
        .DONE     (DONE),
        .ERR      (ERR),
        .STATE    (STATE)
    );

    // record each handshake that will complete on the coming edge
    always @(negedge CLK) begin
        if (!RST && OP_VALID && OP_READY && !BTN[3]) obs_q.push_back(int'(OP_DATA));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [6:0] b);
        BTN = b;
        tick();
        BTN = 7'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_xfer(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        if (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        tick(); tick();
        RST = 1'b0;
        chk("rst_state", STATE, 0);
        chk("rst_digits", DIGITS, 0);
        chk("rst_cur", CUR, 0);
        chk("rst_valid", OP_VALID, 0);
        chk("rst_data", OP_DATA, 0);
        chk("rst_err", ERR, 0);

        // entry 23 with ready held high
        press(P_INC);
        chk("idle_ignores_inc", STATE, 0);
        press(P_RDY);
        chk("enter_edit", STATE, 1);
        press(P_INC); press(P_INC); press(P_INC); press(P_SEL); press(P_INC); press(P_INC);
        chk("digits_23", DIGITS, 16'h0023);
        chk("cur_1", CUR, 1);
        OP_READY = 1'b1;
        exp_q.push_back(23);
        press(P_QUE);
        chk("conv_state", STATE, 2);
        tick(); tick(); tick();
        chk("conv_still", STATE, 2);
        tick();
        chk("submit_valid", OP_VALID, 1);
        chk("submit_data", OP_DATA, 23);
        tick();
        chk("wait_state", STATE, 4);
        chk("valid_dropped", OP_VALID, 0);
        OP_READY = 1'b0;
        check_xfer("xfer_23");
        press(P_CLR);
        chk("wait_ignores_clr", STATE, 4);
        DONE = 1'b1; tick(); DONE = 1'b0;
        chk("show_state", STATE, 5);
        press(P_RDY);
        chk("show_to_edit", STATE, 1);
        chk("show_clears", DIGITS, 0);

        // digit and cursor wrap
        press(P_DEC);
        chk("dec_wrap", DIGITS, 16'h0009);
        press(P_SEL); press(P_SEL);
        chk("cur_2", CUR, 2);
        press(P_SEL); press(P_SEL);
        chk("cur_wrap", CUR, 0);
        press(P_INC);
        chk("inc_wrap", DIGITS, 16'h0000);

        // operand below 2 is rejected
        press(P_INC);
        press(P_QUE);
        for (int i = 0; i < 4; i++) begin
            chk("err_no_valid", OP_VALID, 0);
            tick();
        end
        chk("err_state", STATE, 1);
        chk("err_flag", ERR, 1);
        chk("err_digits", DIGITS, 16'h0001);
        chk("err_no_valid_end", OP_VALID, 0);
        press(P_INC);
        chk("err_cleared", ERR, 0);
        chk("err_inc", DIGITS, 16'h0002);

        // 9999 with a stalled datapath, then resubmit from SHOW
        press(P_CLR);
        press(P_DEC); press(P_SEL); press(P_DEC); press(P_SEL); press(P_DEC); press(P_SEL); press(P_DEC);
        chk("digits_9999", DIGITS, 16'h9999);
        exp_q.push_back(9999);
        press(P_QUE);
        tick(); tick(); tick(); tick();
        chk("stall_submit", STATE, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", OP_VALID, 1);
            chk("stall_data", OP_DATA, 9999);
        end
        OP_READY = 1'b1;
        tick();
        OP_READY = 1'b0;
        chk("stall_wait", STATE, 4);
        check_xfer("xfer_9999");
        DONE = 1'b1; tick(); DONE = 1'b0;
        chk("show_9999", STATE, 5);
        exp_q.push_back(9999);
        press(P_QUE);
        chk("resubmit_conv", STATE, 2);
        tick(); tick(); tick(); tick();
        chk("resubmit_data", OP_DATA, 9999);
        chk("resubmit_valid", OP_VALID, 1);
        OP_READY = 1'b1;
        tick();
        OP_READY = 1'b0;
        check_xfer("xfer_resub");
        DONE = 1'b1; tick(); DONE = 1'b0;
        press(P_RDY);
        chk("back_edit", STATE, 1);
        DONE = 1'b1; tick(); DONE = 1'b0;
        chk("done_ignored", STATE, 1);

        // priority: CLR wins over INC and QUE
        press(P_SEL); press(P_SEL);
        for (int i = 0; i < 5; i++) press(P_INC);
        chk("digits_0500", DIGITS, 16'h0500);
        press(P_CLR | P_INC | P_QUE);
        chk("prio_digits", DIGITS, 0);
        chk("prio_cur", CUR, 0);
        tick();
        chk("prio_state", STATE, 1);

        // CLR during SUBMIT beats a same-cycle transfer
        press(P_INC); press(P_INC);
        press(P_QUE);
        tick(); tick(); tick(); tick();
        chk("clr_sub_valid", OP_VALID, 1);
        OP_READY = 1'b1;
        press(P_CLR);
        OP_READY = 1'b0;
        chk("clr_sub_drop", OP_VALID, 0);
        chk("clr_sub_edit", STATE, 1);
        chk("clr_sub_digits", DIGITS, 16'h0002);
        chk("clr_no_xfer", obs_q.size(), 0);

        // reset in the middle of a conversion
        press(P_QUE);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_state", STATE, 0);
        chk("mid_rst_digits", DIGITS, 0);
        chk("mid_rst_cur", CUR, 0);
        chk("mid_rst_valid", OP_VALID, 0);
        chk("mid_rst_data", OP_DATA, 0);
        chk("mid_rst_err", ERR, 0);
        press(P_RDY);
        for (int i = 0; i < 5; i++) press(P_INC);
        OP_READY = 1'b1;
        exp_q.push_back(5);
        press(P_QUE);
        tick(); tick(); tick(); tick();
        chk("post_rst_data", OP_DATA, 5);
        tick();
        OP_READY = 1'b0;
        chk("post_rst_wait", STATE, 4);
        check_xfer("xfer_5");
        DONE = 1'b1; tick(); DONE = 1'b0;
        press(P_RDY);
        press(P_INC);

`ifdef TIMEOUT_EN
        for (int i = 0; i < 99; i++) tick();
        chk("tmo_not_yet", STATE, 1);
        tick();
        chk("tmo_idle", STATE, 0);
        chk("tmo_digits", DIGITS, 0);
`else
        for (int i = 0; i < 120; i++) tick();
        chk("no_tmo_state", STATE, 1);
        chk("no_tmo_digits", DIGITS, 16'h0001);
`endif

        chk("queue_empty", exp_q.size(), 0);
        chk("obs_empty", obs_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
